// File: rtl/ann_ctrl_pkg.sv
// Shared types and constants for the FC classifier layer sequencer.
// Holds the controller state encoding, the default layer lengths and the class-index width.
package ann_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ACC,
        DRAIN,
        RELU,
        ARGMAX,
        DONE
    } state_t;

    localparam int NUM_LAYERS  = 3;
    localparam int K_WIDTH     = 2;
    localparam int DEF_N_L1    = 400;
    localparam int DEF_N_L2    = 120;
    localparam int DEF_N_L3    = 84;
    localparam int LAYER_LEN [NUM_LAYERS] = '{DEF_N_L1, DEF_N_L2, DEF_N_L3};
    localparam int CLASS_WIDTH = 4;

    function automatic int max_len(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ann_addr_counter.sv
// Weight-address up-counter with sync clear, enable and a programmable terminal count.
// The tc flag is registered alongside the count so it always describes the current address.
module ann_addr_counter #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] last,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  tc
);

    logic [ADDR_WIDTH-1:0] count_reg;
    logic [ADDR_WIDTH-1:0] count_next;
    logic                  tc_reg;

    // Saturate at the terminal count so the address can never run past the layer.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && !tc_reg) begin
            count_next = count_reg + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= (count_next == last);
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;

endmodule

// File: rtl/ann_layer_sequencer.sv
// Start/done controller for the 400->120->84->10 classifier: sequences the three layers on a
// shared weight-address bus, drives accumulate/ReLU enables and resets, and captures the argmax.
module ann_layer_sequencer
    import ann_ctrl_pkg::*;
#(
    parameter int N_L1        = ann_ctrl_pkg::DEF_N_L1,
    parameter int N_L2        = ann_ctrl_pkg::DEF_N_L2,
    parameter int N_L3        = ann_ctrl_pkg::DEF_N_L3,
    parameter int ADDR_WIDTH  = 9,
    parameter int CLASS_WIDTH = ann_ctrl_pkg::CLASS_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CLASS_WIDTH-1:0] class_in,
    output logic [ADDR_WIDTH-1:0]  address,
    output logic                   rst_layer,
    output logic                   rst_relu,
    output logic [2:0]             en_layer,
    output logic [1:0]             en_relu,
    output logic                   busy,
    output logic                   done,
    output logic [CLASS_WIDTH-1:0] class_out
);

    generate
        if ((1 << ADDR_WIDTH) < max_len(N_L1, N_L2, N_L3)) begin : g_addr_width_check
            $error("ADDR_WIDTH too small for the longest layer");
        end
    endgenerate

    state_t               state_reg;
    state_t               state_next;
    logic [K_WIDTH-1:0]   k_reg;
    logic [K_WIDTH-1:0]   k_next;
    logic                 abort_hit;
    logic                 tc;
    logic                 cnt_clear;
    logic                 cnt_enable;
    logic [ADDR_WIDTH-1:0] last_addr;

    logic                 layer_on;
    logic                 relu_on;
    logic [2:0]           en_layer_next;
    logic [1:0]           en_relu_next;

    logic                 rst_layer_reg;
    logic                 rst_relu_reg;
    logic [2:0]           en_layer_reg;
    logic [1:0]           en_relu_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [CLASS_WIDTH-1:0] class_out_reg;

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        abort_hit  = 1'b0;
        case (state_reg)
            IDLE:    if (start && !abort) state_next = CLR;
            CLR: begin
                state_next = ACC;
                k_next     = '0;
            end
            ACC:     if (tc) state_next = DRAIN;
            DRAIN:   state_next = (k_reg < K_WIDTH'(NUM_LAYERS - 1)) ? RELU : ARGMAX;
            RELU: begin
                state_next = ACC;
                k_next     = k_reg + K_WIDTH'(1);
            end
            ARGMAX:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // The result capture in DONE wins over a late abort.
        if (abort && (state_reg != IDLE) && (state_reg != DONE)) begin
            state_next = IDLE;
            abort_hit  = 1'b1;
        end
    end

    always_comb begin
        case (k_next)
            2'd0:    last_addr = ADDR_WIDTH'(N_L1 - 1);
            2'd1:    last_addr = ADDR_WIDTH'(N_L2 - 1);
            default: last_addr = ADDR_WIDTH'(N_L3 - 1);
        endcase
    end

    assign cnt_clear  = (state_next == IDLE) || (state_next == CLR) || (state_next == RELU);
    assign cnt_enable = (state_reg == ACC) && (state_next == ACC);

    ann_addr_counter #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .last   (last_addr),
        .count  (address),
        .tc     (tc)
    );

    // Outputs are decoded from the upcoming state so they appear registered with it.
    assign layer_on = (state_next == ACC) || (state_next == DRAIN);
    assign relu_on  = (state_next == RELU);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_en_layer
            assign en_layer_next[gi] = layer_on && (k_next == K_WIDTH'(gi));
        end
        for (gi = 0; gi < NUM_LAYERS - 1; gi++) begin : g_en_relu
            assign en_relu_next[gi] = relu_on && (k_next == K_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            rst_layer_reg <= 1'b0;
            rst_relu_reg  <= 1'b0;
            en_layer_reg  <= '0;
            en_relu_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            class_out_reg <= '0;
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            rst_layer_reg <= (state_next == CLR) || abort_hit;
            rst_relu_reg  <= (state_next == CLR);
            en_layer_reg  <= en_layer_next;
            en_relu_reg   <= en_relu_next;
            busy_reg      <= (state_next != IDLE);
            done_reg      <= (state_next == DONE);
            if (state_next == DONE) begin
                class_out_reg <= class_in;
            end
        end
    end

    assign rst_layer = rst_layer_reg;
    assign rst_relu  = rst_relu_reg;
    assign en_layer  = en_layer_reg;
    assign en_relu   = en_relu_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign class_out = class_out_reg;

endmodule
